// File: rtl/jump_table_loader_if.sv
// Byte-wide load stream into the jump-label table loader.
// The boot/program loader is the master and the table writer is the slave.
interface jump_table_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/jump_table_loader.sv
// Jump-label table writer: parses {cmd, idx} command bytes from the load stream,
// assembles 16-bit addresses and serves them to the branch mux combinationally.
module jump_table_loader #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    jump_table_loader_if.slave    load,
    input  logic [3:0]            lookup_idx,
    output logic [ADDR_W-1:0]     lookup_addr,
    output logic                  lookup_hit,
    output logic                  load_done,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_CMD = 2'd0,
        S_LO  = 2'd1,
        S_HI  = 2'd2,
        S_WR  = 2'd3
    } state_t;

    localparam logic [3:0] CMD_CLEAR = 4'h0;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_DONE  = 4'hF;

    state_t         state_reg, state_next;
    logic [3:0]     idx_reg;
    logic [7:0]     lo_reg;
    logic [7:0]     hi_reg;
    logic           load_done_reg;
    logic           err_reg;

    logic           ready;
    logic           accept;
    logic           clear_all;
    logic           set_done;
    logic           set_err;
    logic           latch_idx;
    logic           latch_lo;
    logic           latch_hi;
    logic           wr_en;

    logic [ADDR_W-1:0] word_arr  [ENTRIES];
    logic              valid_arr [ENTRIES];

    assign ready           = (state_reg != S_WR);
    assign load.byte_ready = ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_CMD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = load.byte_valid && ready;
        clear_all  = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        latch_idx  = 1'b0;
        latch_lo   = 1'b0;
        latch_hi   = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            S_CMD: begin
                if (accept) begin
                    case (load.byte_in[7:4])
                        CMD_WRITE: begin
                            latch_idx  = 1'b1;
                            state_next = S_LO;
                        end
                        CMD_CLEAR: clear_all = 1'b1;
                        CMD_DONE:  set_done  = 1'b1;
                        default:   set_err   = 1'b1;
                    endcase
                end
            end
            S_LO: begin
                if (accept) begin
                    latch_lo   = 1'b1;
                    state_next = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    latch_hi   = 1'b1;
                    state_next = S_WR;
                end
            end
            S_WR: begin
                wr_en      = 1'b1;
                state_next = S_CMD;
            end
            default: state_next = S_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg       <= '0;
            lo_reg        <= '0;
            hi_reg        <= '0;
            load_done_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (latch_idx) idx_reg <= load.byte_in[3:0];
            if (latch_lo)  lo_reg  <= load.byte_in;
            if (latch_hi)  hi_reg  <= load.byte_in;
            if (clear_all)     load_done_reg <= 1'b0;
            else if (set_done) load_done_reg <= 1'b1;
            // err is sticky until reset
            if (set_err) err_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [ADDR_W-1:0] word_reg;
            logic              valid_reg;

            // CLEAR drops only the valid bit; the stored word survives until rewritten
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (clear_all) begin
                    valid_reg <= 1'b0;
                end else if (wr_en && (idx_reg == 4'(gi))) begin
                    word_reg  <= ADDR_W'({hi_reg, lo_reg});
                    valid_reg <= 1'b1;
                end
            end

            assign word_arr[gi]  = word_reg;
            assign valid_arr[gi] = valid_reg;
        end
    endgenerate

    assign lookup_hit  = valid_arr[lookup_idx];
    assign lookup_addr = lookup_hit ? word_arr[lookup_idx] : '0;
    assign load_done   = load_done_reg;
    assign err         = err_reg;

endmodule
